// File: rtl/rs_age_issue.sv
`default_nettype none
// ============================================================================
// Module   : rs_age_issue
// Brief    : Age-ordered reservation station with CDB/commit wakeup and bypass.
// Revision : 1.0
// ============================================================================
module rs_age_issue #(
    parameter int  RS_DEPTH  = 4,
    parameter int  ROB_DEPTH = 4,
    parameter int  NUM_CDB   = 4,
    parameter int  DATA_W    = 32,
    localparam int TAG_W     = $clog2(ROB_DEPTH),
    localparam int OCC_W     = $clog2(RS_DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              dispatch_valid,
    output logic              dispatch_ready,
    input  logic [31:0]       instr_in,
    input  logic [TAG_W-1:0]  tag_dest_in,
    input  logic [TAG_W-1:0]  tag_A_in,
    input  logic [TAG_W-1:0]  tag_B_in,
    input  logic [DATA_W-1:0] data_A_in,
    input  logic [DATA_W-1:0] data_B_in,
    input  logic              ready_A_in,
    input  logic              ready_B_in,
    input  logic              cdb_valid [NUM_CDB],
    input  logic [TAG_W-1:0]  cdb_tag   [NUM_CDB],
    input  logic [DATA_W-1:0] cdb_data  [NUM_CDB],
    input  logic              rob_commit,
    input  logic [TAG_W-1:0]  rob_commit_tag,
    input  logic [DATA_W-1:0] rob_commit_rd_v,
    output logic              issue_valid,
    input  logic              issue_ready,
    output logic [31:0]       instr_out,
    output logic [TAG_W-1:0]  tag_dest_out,
    output logic [DATA_W-1:0] data_A_out,
    output logic [DATA_W-1:0] data_B_out,
    output logic [OCC_W-1:0]  occupancy
);

    localparam int IDX_W = $clog2(RS_DEPTH);

    logic [RS_DEPTH-1:0] valid_q, valid_d;
    logic [RS_DEPTH-1:0] rdy_a_q, rdy_a_d, rdy_b_q, rdy_b_d;
    logic [RS_DEPTH-1:0] older_q [RS_DEPTH];
    logic [RS_DEPTH-1:0] older_d [RS_DEPTH];
    logic [31:0]         instr_q  [RS_DEPTH];
    logic [31:0]         instr_d  [RS_DEPTH];
    logic [TAG_W-1:0]    tagd_q   [RS_DEPTH];
    logic [TAG_W-1:0]    tagd_d   [RS_DEPTH];
    logic [TAG_W-1:0]    tag_a_q  [RS_DEPTH];
    logic [TAG_W-1:0]    tag_a_d  [RS_DEPTH];
    logic [TAG_W-1:0]    tag_b_q  [RS_DEPTH];
    logic [TAG_W-1:0]    tag_b_d  [RS_DEPTH];
    logic [DATA_W-1:0]   data_a_q [RS_DEPTH];
    logic [DATA_W-1:0]   data_a_d [RS_DEPTH];
    logic [DATA_W-1:0]   data_b_q [RS_DEPTH];
    logic [DATA_W-1:0]   data_b_d [RS_DEPTH];

    // Slot RS_DEPTH of the lookup arrays is the incoming dispatch (bypass path).
    logic [TAG_W-1:0]    look_a [RS_DEPTH+1];
    logic [TAG_W-1:0]    look_b [RS_DEPTH+1];
    logic [RS_DEPTH:0]   hit_a, hit_b;
    logic [DATA_W-1:0]   val_a  [RS_DEPTH+1];
    logic [DATA_W-1:0]   val_b  [RS_DEPTH+1];

    logic [RS_DEPTH-1:0] cand, blocked, win;
    logic [IDX_W-1:0]    free_idx;
    logic                free_found;
    logic                disp_fire, issue_fire;

    always_comb begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            look_a[i] = tag_a_q[i];
            look_b[i] = tag_b_q[i];
        end
        look_a[RS_DEPTH] = tag_A_in;
        look_b[RS_DEPTH] = tag_B_in;
    end

    // Commit is applied first and CDBs are scanned high-to-low, so the
    // lowest-index CDB ends up with the final say.
    always_comb begin
        for (int i = 0; i <= RS_DEPTH; i++) begin
            hit_a[i] = 1'b0;
            hit_b[i] = 1'b0;
            val_a[i] = '0;
            val_b[i] = '0;
            if (rob_commit && rob_commit_tag == look_a[i]) begin
                hit_a[i] = 1'b1;
                val_a[i] = rob_commit_rd_v;
            end
            if (rob_commit && rob_commit_tag == look_b[i]) begin
                hit_b[i] = 1'b1;
                val_b[i] = rob_commit_rd_v;
            end
            for (int c = NUM_CDB - 1; c >= 0; c--) begin
                if (cdb_valid[c] && cdb_tag[c] == look_a[i]) begin
                    hit_a[i] = 1'b1;
                    val_a[i] = cdb_data[c];
                end
                if (cdb_valid[c] && cdb_tag[c] == look_b[i]) begin
                    hit_b[i] = 1'b1;
                    val_b[i] = cdb_data[c];
                end
            end
        end
    end

    always_comb begin
        free_idx   = '0;
        free_found = 1'b0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (!valid_q[i] && !free_found) begin
                free_idx   = IDX_W'(i);
                free_found = 1'b1;
            end
        end
    end

    assign cand = valid_q & rdy_a_q & rdy_b_q;

    always_comb begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            blocked[i] = 1'b0;
            for (int j = 0; j < RS_DEPTH; j++) begin
                if (cand[j] && older_q[j][i]) blocked[i] = 1'b1;
            end
        end
        win = cand & ~blocked;
    end

    always_comb begin
        issue_valid  = |win;
        instr_out    = '0;
        tag_dest_out = '0;
        data_A_out   = '0;
        data_B_out   = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (win[i]) begin
                instr_out    = instr_q[i];
                tag_dest_out = tagd_q[i];
                data_A_out   = data_a_q[i];
                data_B_out   = data_b_q[i];
            end
        end
    end

    assign dispatch_ready = ~&valid_q;
    assign occupancy      = OCC_W'($countones(valid_q));
    assign disp_fire      = dispatch_valid && dispatch_ready;
    assign issue_fire     = issue_valid && issue_ready;

    always_comb begin
        valid_d = valid_q;
        rdy_a_d = rdy_a_q;
        rdy_b_d = rdy_b_q;
        for (int i = 0; i < RS_DEPTH; i++) begin
            older_d[i]  = older_q[i];
            instr_d[i]  = instr_q[i];
            tagd_d[i]   = tagd_q[i];
            tag_a_d[i]  = tag_a_q[i];
            tag_b_d[i]  = tag_b_q[i];
            data_a_d[i] = data_a_q[i];
            data_b_d[i] = data_b_q[i];
            if (valid_q[i] && !rdy_a_q[i] && hit_a[i]) begin
                rdy_a_d[i]  = 1'b1;
                data_a_d[i] = val_a[i];
            end
            if (valid_q[i] && !rdy_b_q[i] && hit_b[i]) begin
                rdy_b_d[i]  = 1'b1;
                data_b_d[i] = val_b[i];
            end
        end
        if (issue_fire) valid_d = valid_d & ~win;
        if (disp_fire) begin
            valid_d[free_idx]  = 1'b1;
            instr_d[free_idx]  = instr_in;
            tagd_d[free_idx]   = tag_dest_in;
            tag_a_d[free_idx]  = tag_A_in;
            tag_b_d[free_idx]  = tag_B_in;
            rdy_a_d[free_idx]  = ready_A_in | hit_a[RS_DEPTH];
            rdy_b_d[free_idx]  = ready_B_in | hit_b[RS_DEPTH];
            data_a_d[free_idx] = (!ready_A_in && hit_a[RS_DEPTH]) ? val_a[RS_DEPTH] : data_A_in;
            data_b_d[free_idx] = (!ready_B_in && hit_b[RS_DEPTH]) ? val_b[RS_DEPTH] : data_B_in;
            for (int i = 0; i < RS_DEPTH; i++) begin
                older_d[i][free_idx] = valid_q[i];
            end
            older_d[free_idx] = '0;
        end
        if (flush) begin
            valid_d = '0;
            for (int i = 0; i < RS_DEPTH; i++) older_d[i] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < RS_DEPTH; i++) older_q[i] <= '0;
        end else begin
            valid_q <= valid_d;
            for (int i = 0; i < RS_DEPTH; i++) older_q[i] <= older_d[i];
        end
    end

    // Payload needs no reset: it is only observed through a valid entry.
    always_ff @(posedge clk) begin
        rdy_a_q <= rdy_a_d;
        rdy_b_q <= rdy_b_d;
        for (int i = 0; i < RS_DEPTH; i++) begin
            instr_q[i]  <= instr_d[i];
            tagd_q[i]   <= tagd_d[i];
            tag_a_q[i]  <= tag_a_d[i];
            tag_b_q[i]  <= tag_b_d[i];
            data_a_q[i] <= data_a_d[i];
            data_b_q[i] <= data_b_d[i];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rs_age_issue.sv
`default_nettype none
// ============================================================================
// Module   : tb_rs_age_issue
// Brief    : Directed bench for rs_age_issue with an age-ordered queue model.
// Revision : 1.0
// ============================================================================
module tb_rs_age_issue;

    localparam int RS_DEPTH = 4;
    localparam int NUM_CDB  = 4;
    localparam int DATA_W   = 32;
    localparam int TAG_W    = 2;

    logic              clk = 1'b0;
    logic              rst, flush, dispatch_valid, dispatch_ready;
    logic [31:0]       instr_in;
    logic [TAG_W-1:0]  tag_dest_in, tag_A_in, tag_B_in;
    logic [DATA_W-1:0] data_A_in, data_B_in;
    logic              ready_A_in, ready_B_in;
    logic              cdb_valid [NUM_CDB];
    logic [TAG_W-1:0]  cdb_tag   [NUM_CDB];
    logic [DATA_W-1:0] cdb_data  [NUM_CDB];
    logic              rob_commit;
    logic [TAG_W-1:0]  rob_commit_tag;
    logic [DATA_W-1:0] rob_commit_rd_v;
    logic              issue_valid, issue_ready;
    logic [31:0]       instr_out;
    logic [TAG_W-1:0]  tag_dest_out;
    logic [DATA_W-1:0] data_A_out, data_B_out;
    logic [2:0]        occupancy;

    rs_age_issue #(.RS_DEPTH(RS_DEPTH), .ROB_DEPTH(4), .NUM_CDB(NUM_CDB), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
        .instr_in(instr_in), .tag_dest_in(tag_dest_in),
        .tag_A_in(tag_A_in), .tag_B_in(tag_B_in),
        .data_A_in(data_A_in), .data_B_in(data_B_in),
        .ready_A_in(ready_A_in), .ready_B_in(ready_B_in),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .rob_commit(rob_commit), .rob_commit_tag(rob_commit_tag),
        .rob_commit_rd_v(rob_commit_rd_v),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .instr_out(instr_out), .tag_dest_out(tag_dest_out),
        .data_A_out(data_A_out), .data_B_out(data_B_out),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]       instr;
        logic [TAG_W-1:0]  td, ta, tb;
        logic [DATA_W-1:0] da, db;
        bit                ra, rb;
    } ent_t;

    ent_t        q[$];          // oldest at the front
    int          errors = 0;
    int          checks = 0;
    bit          chk_en = 0;
    int          m_sz, m_w;
    logic [31:0] m_v;
    ent_t        m_e;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // First matching CDB in index order, otherwise the commit forward.
    function automatic bit bcast(input logic [TAG_W-1:0] t, output logic [DATA_W-1:0] v);
        v = '0;
        for (int c = 0; c < NUM_CDB; c++) begin
            if (cdb_valid[c] && cdb_tag[c] == t) begin
                v = cdb_data[c];
                return 1'b1;
            end
        end
        if (rob_commit && rob_commit_tag == t) begin
            v = rob_commit_rd_v;
            return 1'b1;
        end
        return 1'b0;
    endfunction

    always @(posedge clk) begin : p_model
        if (rst || flush) begin
            q.delete();
        end else begin
            m_sz = q.size();
            m_w  = -1;
            for (int i = 0; i < q.size(); i++)
                if (m_w < 0 && q[i].ra && q[i].rb) m_w = i;
            for (int i = 0; i < q.size(); i++) begin
                if (!q[i].ra && bcast(q[i].ta, m_v)) begin q[i].ra = 1; q[i].da = m_v; end
                if (!q[i].rb && bcast(q[i].tb, m_v)) begin q[i].rb = 1; q[i].db = m_v; end
            end
            if (m_w >= 0 && issue_ready) q.delete(m_w);
            if (dispatch_valid && m_sz < RS_DEPTH) begin
                m_e.instr = instr_in; m_e.td = tag_dest_in;
                m_e.ta = tag_A_in; m_e.tb = tag_B_in;
                m_e.ra = ready_A_in; m_e.da = data_A_in;
                m_e.rb = ready_B_in; m_e.db = data_B_in;
                if (!ready_A_in && bcast(tag_A_in, m_v)) begin m_e.ra = 1; m_e.da = m_v; end
                if (!ready_B_in && bcast(tag_B_in, m_v)) begin m_e.rb = 1; m_e.db = m_v; end
                q.push_back(m_e);
            end
        end
    end

    always @(negedge clk) begin : p_compare
        int   w;
        ent_t e;
        if (chk_en) begin
            w = -1;
            for (int i = 0; i < q.size(); i++)
                if (w < 0 && q[i].ra && q[i].rb) w = i;
            e = '{instr: '0, td: '0, ta: '0, tb: '0, da: '0, db: '0, ra: 0, rb: 0};
            if (w >= 0) e = q[w];
            chk("issue_valid", 32'(issue_valid), 32'(w >= 0));
            chk("instr_out", instr_out, e.instr);
            chk("tag_dest_out", 32'(tag_dest_out), 32'(e.td));
            chk("data_A_out", data_A_out, e.da);
            chk("data_B_out", data_B_out, e.db);
            chk("occupancy", 32'(occupancy), 32'(q.size()));
            chk("dispatch_ready", 32'(dispatch_ready), 32'(q.size() < RS_DEPTH));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        dispatch_valid = 0; instr_in = '0; tag_dest_in = '0;
        tag_A_in = '0; tag_B_in = '0; data_A_in = '0; data_B_in = '0;
        ready_A_in = 0; ready_B_in = 0; flush = 0;
        rob_commit = 0; rob_commit_tag = '0; rob_commit_rd_v = '0;
        for (int c = 0; c < NUM_CDB; c++) begin
            cdb_valid[c] = 0; cdb_tag[c] = '0; cdb_data[c] = '0;
        end
    endtask

    task automatic disp(input logic [31:0] ins, input logic [TAG_W-1:0] td, ta, tb,
                        input logic [DATA_W-1:0] da, db, input bit ra, rb);
        dispatch_valid = 1; instr_in = ins; tag_dest_in = td;
        tag_A_in = ta; tag_B_in = tb; data_A_in = da; data_B_in = db;
        ready_A_in = ra; ready_B_in = rb;
    endtask

    task automatic set_cdb(input int c, input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
        cdb_valid[c] = 1; cdb_tag[c] = t; cdb_data[c] = d;
    endtask

    initial begin
        clr();
        issue_ready = 0;
        rst = 1;
        tick();
        rst = 0;
        chk("rst_dispatch_ready", 32'(dispatch_ready), 32'd1);
        chk("rst_issue_valid", 32'(issue_valid), 32'd0);
        chk("rst_occupancy", 32'(occupancy), 32'd0);
        chk("rst_instr_out", instr_out, 32'd0);
        chk("rst_data_A_out", data_A_out, 32'd0);
        chk_en = 1;

        // Age order: I1, I2 ready; I0 woken later.
        disp(32'h100, 2'd0, 2'd1, 2'd2, 32'h0, 32'h0, 0, 0); tick();
        disp(32'h101, 2'd1, 2'd0, 2'd0, 32'hA1, 32'hB1, 1, 1); tick();
        disp(32'h102, 2'd2, 2'd0, 2'd0, 32'hA2, 32'hB2, 1, 1); tick();
        clr();
        chk("age_occ", 32'(occupancy), 32'd3);
        chk("age_model_occ", 32'(q.size()), 32'd3);
        chk("age_first", instr_out, 32'h101);
        chk("age_first_A", data_A_out, 32'hA1);
        issue_ready = 1; tick();
        chk("age_second", instr_out, 32'h102);
        tick();
        chk("age_I0_waiting", 32'(issue_valid), 32'd0);
        set_cdb(0, 2'd1, 32'h11); set_cdb(3, 2'd2, 32'h22); tick(); clr();
        chk("age_third", instr_out, 32'h100);
        chk("age_third_A", data_A_out, 32'h11);
        chk("age_third_B", data_B_out, 32'h22);
        tick();
        chk("age_drained", 32'(occupancy), 32'd0);

        // Fill and backpressure.
        issue_ready = 0;
        for (int k = 0; k < 4; k++) begin
            disp(32'h200 + k, 2'(k), 2'd0, 2'd0, 32'h1000 + k, 32'h2000 + k, 1, 1);
            tick();
        end
        clr();
        chk("full_dispatch_ready", 32'(dispatch_ready), 32'd0);
        chk("full_occ", 32'(occupancy), 32'd4);
        disp(32'h204, 2'd0, 2'd0, 2'd0, 32'h0, 32'h0, 1, 1); tick(); clr();
        chk("full_ignored_occ", 32'(occupancy), 32'd4);
        chk("full_oldest", instr_out, 32'h200);
        issue_ready = 1; tick(); issue_ready = 0;
        chk("after_issue_occ", 32'(occupancy), 32'd3);
        chk("after_issue_ready", 32'(dispatch_ready), 32'd1);
        chk("after_issue_next", instr_out, 32'h201);
        issue_ready = 1; tick(); tick(); tick();
        chk("fill_drained", 32'(occupancy), 32'd0);

        // Dispatch bypass, lowest CDB wins.
        issue_ready = 0;
        disp(32'h300, 2'd3, 2'd3, 2'd0, 32'h0, 32'h77, 0, 1);
        set_cdb(1, 2'd3, 32'hABCD); set_cdb(2, 2'd3, 32'hEEEE);
        tick(); clr();
        chk("bypass_valid", 32'(issue_valid), 32'd1);
        chk("bypass_A", data_A_out, 32'hABCD);
        chk("bypass_B", data_B_out, 32'h77);
        issue_ready = 1; tick();

        // CDB beats commit; commit alone also wakes; dispatch+issue together.
        issue_ready = 0;
        disp(32'h400, 2'd0, 2'd2, 2'd0, 32'h0, 32'h55, 0, 1); tick(); clr();
        chk("cc_not_ready", 32'(issue_valid), 32'd0);
        rob_commit = 1; rob_commit_tag = 2'd2; rob_commit_rd_v = 32'h5;
        set_cdb(0, 2'd2, 32'h9); tick(); clr();
        chk("cc_cdb_wins", data_A_out, 32'h9);
        issue_ready = 1;
        disp(32'h401, 2'd1, 2'd1, 2'd0, 32'h0, 32'h66, 0, 1); tick(); clr();
        chk("swap_occ", 32'(occupancy), 32'd1);
        chk("swap_not_ready", 32'(issue_valid), 32'd0);
        rob_commit = 1; rob_commit_tag = 2'd1; rob_commit_rd_v = 32'h33; tick(); clr();
        chk("commit_A", data_A_out, 32'h33);
        chk("commit_instr", instr_out, 32'h401);
        tick();

        // Flush overrides dispatch and wakeup.
        issue_ready = 0;
        for (int k = 0; k < 3; k++) begin
            disp(32'h500 + k, 2'(k), 2'd0, 2'd0, 32'h0, 32'h0, 1, 1);
            tick();
        end
        disp(32'h5FF, 2'd3, 2'd0, 2'd0, 32'h1, 32'h2, 1, 1);
        set_cdb(0, 2'd0, 32'h1234);
        flush = 1; tick(); clr();
        chk("flush_occ", 32'(occupancy), 32'd0);
        chk("flush_issue_valid", 32'(issue_valid), 32'd0);
        chk("flush_dispatch_ready", 32'(dispatch_ready), 32'd1);
        tick();
        chk("flush_not_stored", 32'(occupancy), 32'd0);

        // Mixed traffic checked against the model every cycle.
        for (int n = 0; n < 400; n++) begin
            clr();
            if ($urandom_range(0, 2) != 0)
                disp($urandom, 2'($urandom), 2'($urandom), 2'($urandom),
                     $urandom, $urandom, 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0));
            for (int c = 0; c < NUM_CDB; c++)
                if ($urandom_range(0, 3) == 0) set_cdb(c, 2'($urandom), $urandom);
            if ($urandom_range(0, 3) == 0) begin
                rob_commit = 1; rob_commit_tag = 2'($urandom); rob_commit_rd_v = $urandom;
            end
            issue_ready = 1'($urandom_range(0, 1));
            flush = ($urandom_range(0, 49) == 0);
            tick();
        end
        clr();
        issue_ready = 0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rs_age_issue.md
# rs_age_issue

Parametrised reservation station for the out-of-order core, sitting between the instruction queue (dispatch side) and one functional unit (issue side). It holds up to RS_DEPTH waiting instructions and captures operands from NUM_CDB result buses and from ROB commit forwarding. It issues the oldest ready entry through a valid/ready handshake. Compared with the previous station it adds configurable CDB count and data width, true age-ordered selection, dispatch-cycle operand bypass, and single-cycle issue/free with no ALU response hold.

## Interface
Parameters:
- RS_DEPTH, 4, number of entries (power of two, ≥2)
- ROB_DEPTH, 4, ROB entries; TAG_W = $clog2(ROB_DEPTH)
- NUM_CDB, 4, number of CDB broadcast ports
- DATA_W, 32, operand width; instruction word fixed at 32 bits

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  synchronous clear of all entries (mispredict)
- dispatch_valid  in  1  dispatch request from instruction queue
- dispatch_ready  out  1  a free entry exists
- instr_in  in  32  instruction word
- tag_dest_in  in  TAG_W  destination ROB tag
- tag_A_in / tag_B_in  in  TAG_W  source ROB tags
- data_A_in / data_B_in  in  DATA_W  source values
- ready_A_in / ready_B_in  in  1  source value valid
- cdb_valid[NUM_CDB]  in  1 each  broadcast valid
- cdb_tag[NUM_CDB]  in  TAG_W each  broadcast tag
- cdb_data[NUM_CDB]  in  DATA_W each  broadcast value
- rob_commit  in  1  commit forward valid
- rob_commit_tag  in  TAG_W  committing tag
- rob_commit_rd_v  in  DATA_W  committing value
- issue_valid  out  1  an entry is ready to issue
- issue_ready  in  1  functional unit accepts
- instr_out  out  32  issued instruction
- tag_dest_out  out  TAG_W  issued destination tag
- data_A_out / data_B_out  out  DATA_W  issued operands
- occupancy  out  $clog2(RS_DEPTH)+1  valid entry count

## Operation
- Entry state: valid, instr, tag_dest, {tag, data, ready} per source. Age matrix older[i][j] is set when entry i was dispatched before entry j.
- Dispatch fires when dispatch_valid && dispatch_ready. It writes the lowest-index free entry k and sets older[i][k]=valid[i] for all i, and older[k][*]=0.
- Dispatch bypass: if ready_X_in=0 and the incoming tag matches a valid CDB or commit tag in the same cycle, the entry is written with ready=1 and the broadcast value.
- Wakeup: for each valid, not-ready source, a tag match captures the data and sets ready at the edge.
  - Among CDBs, the lowest index wins.
  - A CDB match beats a commit match.
  - Ready sources ignore broadcasts.
- Select (combinational from registered state): the candidate is a valid entry with both sources ready and no other ready entry older than it. There is exactly one winner.
- issue_valid = a candidate exists. The outputs present the winner; they are all-zero when issue_valid=0.
- Issue fires when issue_valid && issue_ready. The winner's valid clears at the edge. The functional unit must not assume outputs hold when issue_ready=0.
- dispatch_ready = !(all entries valid), computed from registered state. An entry freed by issue is not reusable in the same cycle.
- occupancy = popcount(valid).

## Timing
- Reset/flush (same behaviour, one cycle):
  - all valid=0, age matrix cleared
  - issue_valid=0, outputs 0, dispatch_ready=1, occupancy=0
  - flush overrides a simultaneous dispatch, issue or wakeup
- Dispatch to issue: an entry dispatched with both sources ready (or bypassed) at edge N is eligible in cycle N+1, giving minimum latency 1.
- Wakeup to issue: a CDB match at edge N makes the entry eligible in cycle N+1. There is no same-cycle CDB-to-issue path.
- Simultaneous dispatch and issue in one cycle are both performed; occupancy is unchanged.
- When full, dispatch_valid is ignored and no state changes.
- Tag 0 is an ordinary tag; readiness is governed only by the ready bits.

## Test plan
- Reset then idle: assert rst one cycle -> dispatch_ready=1, issue_valid=0, occupancy=0, all outputs 0.
- Age order: dispatch I0 (tags A=1, B=2, not ready), then I1 and I2 with ready operands. Then broadcast CDB0 tag1=0x11 and CDB3 tag2=0x22 -> issue order I1, I2, I0; I0 issues with data_A=0x11, data_B=0x22.
- Fill and backpressure:
  - Dispatch 4 ready entries with issue_ready=0 -> dispatch_ready=0, occupancy=4, fifth dispatch ignored.
  - Then issue_ready=1 for 1 cycle -> occupancy=3, dispatch_ready=1 next cycle.
- Dispatch bypass: dispatch tag_A_in=3, ready_A_in=0 while cdb_valid[1]=1, cdb_tag[1]=3, data 0xABCD -> issue next cycle with data_A_out=0xABCD.
- Commit vs CDB: same cycle, rob_commit tag 2 = 0x5 and cdb[0] tag 2 = 0x9 -> captured value 0x9.
- Flush: with 3 entries valid, assert flush together with dispatch_valid -> occupancy=0, issue_valid=0 next cycle, and the dispatched instruction is not stored.
